// File: rtl/bus_initiator_pkg.sv
// bus_initiator_pkg: shared state encodings, bus constants and helpers for the bus initiator
package bus_initiator_pkg;
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;
   localparam logic [3:0]  WSTRB_READ   = 4'b0000;
   localparam logic [31:0] SYSTICK_BASE = 32'h8000_0100;
   function automatic logic is_read(input logic [3:0] wstrb);
      return wstrb == WSTRB_READ;
   endfunction
   // counter width able to hold n, never narrower than one bit
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction
endpackage

// File: rtl/bus_initiator_timeout.sv
// bus_initiator_timeout: saturating ACCESS-cycle counter that flags the abort edge
//   clk, reset (async, active-high) | run: count this cycle | clear: zero the count
//   expired: this edge brings the count to TIMEOUT_CYCLES (never set when TIMEOUT_CYCLES==0)
module bus_initiator_timeout
   import bus_initiator_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic clear,
   output logic expired
);
   localparam int W = cnt_width(TIMEOUT_CYCLES);
   localparam logic [W-1:0] SAT  = W'(TIMEOUT_CYCLES);
   localparam logic [W-1:0] LAST = W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   logic [W-1:0] r_cnt;
   always_ff @(posedge clk or posedge reset)
      if (reset) r_cnt <= '0;
      else if (clear) r_cnt <= '0;
      else if (run && r_cnt != SAT) r_cnt <= r_cnt + W'(1);
   // fire one cycle early so the abort edge is the one where the count hits the limit
   assign expired = (TIMEOUT_CYCLES != 0) && run && (r_cnt == LAST);
endmodule

// File: rtl/bus_initiator.sv
// bus_initiator: turns single valid/ready commands into one native-bus transaction each
//   cmd_*: command port (wstrb 0 = read) | rsp_*: response port (rdata, err)
//   mem_*: native memory bus towards the target | clk, reset (async, active-high)
module bus_initiator
   import bus_initiator_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter bit ALIGN_CHECK    = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   input  logic [3:0]  cmd_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);
   state_t      r_state;
   logic        r_mem_valid;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic [3:0]  r_mem_wstrb;
   logic        r_rsp_valid;
   logic [31:0] r_rsp_rdata;
   logic        r_rsp_err;
   logic        w_expired;
   logic        w_in_access;
   logic        w_leave;
   assign w_in_access = r_state == ST_ACCESS;
   assign w_leave     = w_in_access && (mem_ready || w_expired);
   bus_initiator_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .run    (w_in_access),
      .clear  (w_leave),
      .expired(w_expired)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_state     <= ST_IDLE;
         r_mem_valid <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_wstrb <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE:
               if (cmd_valid) begin
                  if (ALIGN_CHECK && cmd_addr[1:0] != 2'b00) begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_rdata <= '0;
                     r_rsp_err   <= 1'b1;
                     r_state     <= ST_RESP;
                  end else begin
                     r_mem_addr  <= cmd_addr;
                     r_mem_wdata <= cmd_wdata;
                     r_mem_wstrb <= cmd_wstrb;
                     r_mem_valid <= 1'b1;
                     r_state     <= ST_ACCESS;
                  end
               end
            ST_ACCESS:
               // mem_ready takes priority over a timeout landing on the same edge
               if (mem_ready || w_expired) begin
                  r_mem_valid <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= (mem_ready && is_read(r_mem_wstrb)) ? mem_rdata : '0;
                  r_rsp_err   <= !mem_ready;
                  r_state     <= ST_RESP;
               end
            ST_RESP:
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            default: r_state <= ST_IDLE;
         endcase
      end
   assign cmd_ready = r_state == ST_IDLE;
   assign mem_valid = r_mem_valid;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_wstrb = r_mem_wstrb;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_bus_initiator.sv
// tb_bus_initiator: directed and random commands against a transaction-level expectation model
module tb_bus_initiator;
   import bus_initiator_pkg::*;
   localparam int TO = 4;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_wstrb = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = '0;
   int n_vec = 0;
   int n_err = 0;
   always #5 clk = ~clk;
   bus_initiator #(.TIMEOUT_CYCLES(TO), .ALIGN_CHECK(1'b1)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   // One command from a negedge in IDLE; the target answers after `waits` wait cycles.
   // Expectations come from the transaction rules, not from the FSM.
   task automatic do_cmd(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                         input int waits, input logic [31:0] rd, input int hold);
      bit          mis   = a[1:0] != 2'b00;
      bit          tmo   = !mis && (waits + 1 > TO);
      int          n_mem = mis ? 0 : (tmo ? TO : waits + 1);
      bit          e_err = mis || tmo;
      logic [31:0] e_rd  = (!e_err && ws == WSTRB_READ) ? rd : 32'h0;
      int          lat;
      int          mem_cnt = 0;
      chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_addr = a; cmd_wdata = wd; cmd_wstrb = ws;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 40) begin
         mem_ready = 1'b0;
         if (mem_valid) begin
            mem_cnt++;
            chk("mem_addr", mem_addr, a);
            chk("mem_wdata", mem_wdata, wd);
            chk("mem_wstrb", 32'(mem_wstrb), 32'(ws));
            mem_ready = mem_cnt == waits + 1;
         end
         mem_rdata = mem_ready ? rd : $urandom;
         @(negedge clk);
         lat++;
      end
      mem_ready = 1'b0;
      chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
      chk("latency", 32'(lat), 32'(n_mem + 1));
      chk("mem_cycles", 32'(mem_cnt), 32'(n_mem));
      chk("mem_valid_done", 32'(mem_valid), 32'd0);
      chk("rsp_err", 32'(rsp_err), 32'(e_err));
      chk("rsp_rdata", rsp_rdata, e_rd);
      for (int i = 0; i < hold; i++) begin
         cmd_valid = 1'b1; cmd_addr = {$urandom} & 32'hFFFF_FFFC; cmd_wstrb = 4'hF;
         mem_ready = 1'($urandom); mem_rdata = $urandom;
         @(negedge clk);
         chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("hold_rsp_rdata", rsp_rdata, e_rd);
         chk("hold_rsp_err", 32'(rsp_err), 32'(e_err));
         chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
         chk("hold_mem_valid", 32'(mem_valid), 32'd0);
      end
      cmd_valid = 1'b0; mem_ready = 1'b0; rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
      chk("cmd_ready_back", 32'(cmd_ready), 32'd1);
   endtask
   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_valid", 32'(mem_valid), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      // write, zero waits
      do_cmd(SYSTICK_BASE + 32'h8, 32'd32, 4'hF, 0, 32'h0, 0);
      // read, three waits (ready lands on the timeout edge and must win)
      do_cmd(SYSTICK_BASE + 32'h8, 32'h0, WSTRB_READ, 3, 32'd32, 0);
      // misaligned read
      do_cmd(SYSTICK_BASE + 32'h2, 32'h0, WSTRB_READ, 0, 32'hDEAD_BEEF, 0);
      // target never answers
      do_cmd(SYSTICK_BASE + 32'h4, 32'h0, WSTRB_READ, 1000, 32'h1234_5678, 0);
      // long response backpressure with a command waiting
      do_cmd(SYSTICK_BASE, 32'h0, WSTRB_READ, 1, 32'hCAFE_F00D, 10);
      for (int k = 0; k < 24; k++) begin
         logic [31:0] a  = $urandom;
         logic [3:0]  ws = ($urandom_range(0, 1) == 0) ? WSTRB_READ : 4'($urandom_range(1, 15));
         if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
         do_cmd(a, $urandom, ws, $urandom_range(0, 6), $urandom, $urandom_range(0, 3));
      end
      // reset during ACCESS drops mem_valid without a clock edge
      cmd_valid = 1'b1; cmd_addr = SYSTICK_BASE + 32'h8; cmd_wstrb = WSTRB_READ;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("pre_rst_mem_valid", 32'(mem_valid), 32'd1);
      @(negedge clk);
      #3 reset = 1'b1;
      #1;
      chk("async_rst_mem_valid", 32'(mem_valid), 32'd0);
      chk("async_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      // reset during RESP drops rsp_valid without a clock edge
      cmd_valid = 1'b1; cmd_addr = SYSTICK_BASE + 32'h3;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      do_cmd(SYSTICK_BASE + 32'h8, 32'h55AA_33CC, 4'hF, 2, 32'h0, 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
